// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: block type, controller states,
// inverse S-box table and small GF(2^8) helpers.
package aes_pkg;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic int nr_f(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         final_round_i,
  output logic [127:0] st_o
);

  block_t shifted, subbed, keyed, mixed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a  = col[31-8*i -: 8];
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Column-major byte layout: byte (row r, col c) is index 4*c+r, byte 0 at MSBs.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = st_i[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    subbed = '0;
    for (int i = 0; i < 16; i++) begin
      subbed[127-8*i -: 8] = INV_SBOX[shifted[127-8*i -: 8]];
    end
  end

  assign keyed = subbed ^ rk_i;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
    end
  end

  assign st_o = final_round_i ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one round per clock over a captured key chain,
// valid/ready on the input side and a held result released by yumi.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter  int KEY_BITS   = 256,
  localparam int NR         = nr_f(KEY_BITS),
  localparam int CHAIN_BITS = (NR + 1) * 128
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [127:0]          ciphertext_i,
  input  logic [CHAIN_BITS-1:0] key_chain_i,
  output logic                  v_o,
  output logic [127:0]          plaintext_o,
  input  logic                  yumi_i
);

  localparam int RND_W = 4;

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_decrypt_iter: KEY_BITS must be 128, 192 or 256");
  end

  state_e                state_q, state_d;
  logic [RND_W-1:0]      rnd_q, rnd_d;
  block_t                st_q, st_d;
  block_t                pt_q, pt_d;
  logic [CHAIN_BITS-1:0] key_q, key_d;
  block_t                rk;
  block_t                round_out;
  logic                  final_round;

  // Round key picked straight from the captured chain by round index.
  always_comb begin
    rk = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rnd_q == RND_W'(i)) rk = key_q[CHAIN_BITS-1-128*i -: 128];
    end
  end

  assign final_round = (rnd_q == '0);

  aes_inv_round u_inv_round (
    .st_i          (st_q),
    .rk_i          (rk),
    .final_round_i (final_round),
    .st_o          (round_out)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    st_d    = st_q;
    pt_d    = pt_q;
    key_d   = key_q;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          key_d   = key_chain_i;
          st_d    = ciphertext_i ^ key_chain_i[127:0];
          rnd_d   = RND_W'(NR - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (final_round) begin
          pt_d    = round_out;
          state_d = DONE;
        end else begin
          st_d  = round_out;
          rnd_d = rnd_q - 1'b1;
        end
      end
      DONE: begin
        if (yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      pt_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      st_q    <= st_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign v_o         = (state_q == DONE);
  assign plaintext_o = pt_q;

endmodule
